// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared SDRAM command encodings, widths and refresh FSM states
package sdram_pkg;

    localparam int ADDR_W = 13;
    localparam int BANK_W = 2;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_AR  = 4'b0001;

    localparam logic [ADDR_W-1:0] ADDR_IDLE    = 13'h1FFF;
    localparam logic [ADDR_W-1:0] ADDR_PRE_ALL = 13'h0400;
    localparam logic [BANK_W-1:0] BANK_IDLE    = 2'b11;
    localparam logic [BANK_W-1:0] BANK_PRE     = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_PRE  = 3'b001,
        ST_TRP  = 3'b011,
        ST_AR   = 3'b010,
        ST_TRFC = 3'b110,
        ST_END  = 3'b111
    } ref_state_e;

endpackage

// File: rtl/sdram_ref_timer.sv
// rtl/sdram_ref_timer.sv - refresh interval counter and saturating postponed-refresh credit
module sdram_ref_timer
    import sdram_pkg::*;
#(
    parameter int T_REFI_CYC   = 750,
    parameter int MAX_POSTPONE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_end,
    input  logic       ar_issued,
    output logic [3:0] pending_q,
    output logic [3:0] pending_d,
    output logic       overflow_q
);

    localparam int CNT_W = $clog2(T_REFI_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             overflow_d;
    logic             tick;

    assign tick = init_end && (cnt_q == CNT_W'(T_REFI_CYC - 1));

    always_comb begin
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (!init_end || tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        // A tick and an AR in the same cycle cancel out.
        if (tick && !ar_issued) begin
            if (pending_q == 4'(MAX_POSTPONE)) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + 4'd1;
            end
        end else if (!tick && ar_issued) begin
            pending_d = pending_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: rtl/sdram_ref.sv
// rtl/sdram_ref.sv - SDRAM auto-refresh controller: PRE then one or a batch of AR per grant
module sdram_ref
    import sdram_pkg::*;
#(
    parameter int T_REFI_CYC   = 750,
    parameter int T_RP_CYC     = 2,
    parameter int T_RFC_CYC    = 7,
    parameter int MAX_POSTPONE = 8,
    parameter int BATCH        = 0
) (
    input  logic              ref_clk,
    input  logic              ref_rst,
    input  logic              init_end,
    input  logic              ref_en,
    output logic [3:0]        ref_cmd,
    output logic [BANK_W-1:0] ref_bank,
    output logic [ADDR_W-1:0] ref_addr,
    output logic              ref_req,
    output logic              ref_urgent,
    output logic              ref_end,
    output logic              ref_overflow,
    output logic [3:0]        ref_pending
);

    localparam int WAIT_MAX = (T_RFC_CYC > T_RP_CYC) ? T_RFC_CYC : T_RP_CYC;
    localparam int WAIT_W   = $clog2(WAIT_MAX);

    ref_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [3:0]        batch_q, batch_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [BANK_W-1:0] bank_q, bank_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              req_q, req_d;
    logic              urgent_q, urgent_d;
    logic              end_q, end_d;
    logic [3:0]        pending_q, pending_d;
    logic              overflow_q;

    sdram_ref_timer #(
        .T_REFI_CYC  (T_REFI_CYC),
        .MAX_POSTPONE(MAX_POSTPONE)
    ) u_timer (
        .clk       (ref_clk),
        .rst       (ref_rst),
        .init_end  (init_end),
        .ar_issued (state_q == ST_AR),
        .pending_q (pending_q),
        .pending_d (pending_d),
        .overflow_q(overflow_q)
    );

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        batch_d = batch_q;
        case (state_q)
            ST_IDLE: begin
                if (ref_en && pending_q != 4'd0) begin
                    state_d = ST_PRE;
                    batch_d = (BATCH != 0) ? pending_q : 4'd1;
                end
            end
            ST_PRE: begin
                state_d = ST_TRP;
                wait_d  = WAIT_W'(T_RP_CYC - 2);
            end
            ST_TRP: begin
                if (wait_q == '0) state_d = ST_AR;
                else              wait_d  = wait_q - 1'b1;
            end
            ST_AR: begin
                state_d = ST_TRFC;
                wait_d  = WAIT_W'(T_RFC_CYC - 2);
                batch_d = batch_q - 4'd1;
            end
            ST_TRFC: begin
                if (wait_q == '0) state_d = (batch_q != 4'd0) ? ST_AR : ST_END;
                else              wait_d  = wait_q - 1'b1;
            end
            ST_END:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with state_q.
        cmd_d    = CMD_NOP;
        bank_d   = BANK_IDLE;
        addr_d   = ADDR_IDLE;
        if (state_d == ST_PRE) begin
            cmd_d  = CMD_PRE;
            bank_d = BANK_PRE;
            addr_d = ADDR_PRE_ALL;
        end else if (state_d == ST_AR) begin
            cmd_d  = CMD_AR;
        end
        end_d    = (state_d == ST_END);
        req_d    = (state_d == ST_IDLE) && (pending_d != 4'd0) && init_end;
        urgent_d = (pending_d == 4'(MAX_POSTPONE));
    end

    always_ff @(posedge ref_clk) begin
        if (ref_rst) begin
            state_q  <= ST_IDLE;
            wait_q   <= '0;
            batch_q  <= '0;
            cmd_q    <= CMD_NOP;
            bank_q   <= BANK_IDLE;
            addr_q   <= ADDR_IDLE;
            req_q    <= 1'b0;
            urgent_q <= 1'b0;
            end_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            batch_q  <= batch_d;
            cmd_q    <= cmd_d;
            bank_q   <= bank_d;
            addr_q   <= addr_d;
            req_q    <= req_d;
            urgent_q <= urgent_d;
            end_q    <= end_d;
        end
    end

    assign ref_cmd      = cmd_q;
    assign ref_bank     = bank_q;
    assign ref_addr     = addr_q;
    assign ref_req      = req_q;
    assign ref_urgent   = urgent_q;
    assign ref_end      = end_q;
    assign ref_overflow = overflow_q;
    assign ref_pending  = pending_q;

endmodule

// File: tb/tb_sdram_ref.sv
// tb/tb_sdram_ref.sv - directed scoreboard bench for sdram_ref (single-AR and batch instances)
module tb_sdram_ref;

    localparam logic [3:0] NOP = 4'b0111;
    localparam logic [3:0] PRE = 4'b0010;
    localparam logic [3:0] ARF = 4'b0001;
    localparam int         TRP  = 2;
    localparam int         TRFC = 7;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    logic rst_a, init_a, en_a, rst_b, init_b, en_b;
    logic [3:0]  cmd_a, cmd_b, pend_a, pend_b;
    logic [1:0]  bank_a, bank_b;
    logic [12:0] addr_a, addr_b;
    logic req_a, req_b, urg_a, urg_b, end_a, end_b, ovf_a, ovf_b;

    typedef struct {
        int         c;
        logic [3:0] p;
        logic       u;
        logic       o;
        logic       r;
    } sb_t;

    logic [4:0] trq[$];
    sb_t        sbq[$];

    sdram_ref #(.T_REFI_CYC(20), .T_RP_CYC(TRP), .T_RFC_CYC(TRFC), .MAX_POSTPONE(4), .BATCH(0)) dut_a (
        .ref_clk(clk), .ref_rst(rst_a), .init_end(init_a), .ref_en(en_a),
        .ref_cmd(cmd_a), .ref_bank(bank_a), .ref_addr(addr_a), .ref_req(req_a),
        .ref_urgent(urg_a), .ref_end(end_a), .ref_overflow(ovf_a), .ref_pending(pend_a));

    sdram_ref #(.T_REFI_CYC(20), .T_RP_CYC(TRP), .T_RFC_CYC(TRFC), .MAX_POSTPONE(4), .BATCH(1)) dut_b (
        .ref_clk(clk), .ref_rst(rst_b), .init_end(init_b), .ref_en(en_b),
        .ref_cmd(cmd_b), .ref_bank(bank_b), .ref_addr(addr_b), .ref_req(req_b),
        .ref_urgent(urg_b), .ref_end(end_b), .ref_overflow(ovf_b), .ref_pending(pend_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push_trace(input int n_ar);
        trq.push_back({PRE, 1'b0});
        for (int i = 0; i < TRP - 1; i++) trq.push_back({NOP, 1'b0});
        for (int k = 0; k < n_ar; k++) begin
            trq.push_back({ARF, 1'b0});
            for (int i = 0; i < TRFC - 1; i++) trq.push_back({NOP, 1'b0});
        end
        trq.push_back({NOP, 1'b1});
    endtask

    task automatic run_trace(input bit sel, input int drop_idx);
        logic [4:0] e;
        int idx = 0;
        while (trq.size() > 0) begin
            @(negedge clk);
            e = trq.pop_front();
            chk("trace_cmd", sel ? cmd_b : cmd_a, e[4:1]);
            chk("trace_end", sel ? end_b : end_a, e[0]);
            if (e[4:1] == PRE) begin
                chk("pre_addr", sel ? addr_b : addr_a, 13'h0400);
                chk("pre_bank", sel ? bank_b : bank_a, 2'b00);
                chk("pre_req_low", sel ? req_b : req_a, 1'b0);
            end
            if (idx == drop_idx) begin
                if (sel) en_b = 1'b0;
                else     en_a = 1'b0;
            end
            idx++;
        end
    endtask

    initial begin
        sb_t s;
        rst_a = 1'b1; init_a = 1'b0; en_a = 1'b0;
        rst_b = 1'b1; init_b = 1'b0; en_b = 1'b0;

        @(negedge clk);
        chk("rst_cmd", cmd_a, NOP);
        chk("rst_bank", bank_a, 2'b11);
        chk("rst_addr", addr_a, 13'h1FFF);
        chk("rst_req", req_a, 1'b0);
        chk("rst_urgent", urg_a, 1'b0);
        chk("rst_end", end_a, 1'b0);
        chk("rst_overflow", ovf_a, 1'b0);
        chk("rst_pending", pend_a, 4'd0);
        wait_until(3);
        rst_a = 1'b0;

        // Single refresh after init completes.
        wait_until(100);
        init_a = 1'b1;
        for (int i = 0; i < 60 && !req_a; i++) @(negedge clk);
        chk("first_req_cycle", 16'(cyc), 16'd120);
        chk("first_pending", pend_a, 4'd1);
        en_a = 1'b1;
        push_trace(1);
        run_trace(1'b0, -1);
        chk("end_cycle", 16'(cyc), 16'd130);
        chk("pending_after_ar", pend_a, 4'd0);
        en_a = 1'b0;

        // Grant dropped during tRFC must not cut the sequence short.
        for (int i = 0; i < 40 && !req_a; i++) @(negedge clk);
        chk("second_req_cycle", 16'(cyc), 16'd140);
        en_a = 1'b1;
        push_trace(1);
        run_trace(1'b0, 3);
        chk("drop_pending", pend_a, 4'd0);
        en_a = 1'b0;

        // AR lands on cycle 179, which is also an interval tick.
        wait_until(176);
        chk("coinc_pending_before", pend_a, 4'd1);
        en_a = 1'b1;
        push_trace(1);
        run_trace(1'b0, -1);
        chk("coinc_pending_after", pend_a, 4'd1);
        chk("coinc_overflow", ovf_a, 1'b0);
        en_a = 1'b0;

        // Reset while in tRP.
        @(negedge clk);
        en_a = 1'b1;
        @(negedge clk);
        chk("rst_seq_pre", cmd_a, PRE);
        en_a = 1'b0;
        @(negedge clk);
        chk("rst_seq_trp", cmd_a, NOP);
        rst_a = 1'b1;
        @(negedge clk);
        chk("midrst_cmd", cmd_a, NOP);
        chk("midrst_pending", pend_a, 4'd0);
        chk("midrst_overflow", ovf_a, 1'b0);
        chk("midrst_req", req_a, 1'b0);
        chk("midrst_addr", addr_a, 13'h1FFF);
        rst_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_idle_cmd", cmd_a, NOP);
            chk("post_rst_idle_end", end_a, 1'b0);
        end

        // Credit accumulation with no grant, then saturation and overflow.
        wait_until(200);
        rst_b = 1'b0;
        wait_until(210);
        init_b = 1'b1;
        sbq.push_back('{229, 4'd0, 1'b0, 1'b0, 1'b0});
        sbq.push_back('{230, 4'd1, 1'b0, 1'b0, 1'b1});
        sbq.push_back('{250, 4'd2, 1'b0, 1'b0, 1'b1});
        sbq.push_back('{270, 4'd3, 1'b0, 1'b0, 1'b1});
        sbq.push_back('{290, 4'd4, 1'b1, 1'b0, 1'b1});
        sbq.push_back('{309, 4'd4, 1'b1, 1'b0, 1'b1});
        sbq.push_back('{310, 4'd4, 1'b1, 1'b1, 1'b1});
        do begin
            @(negedge clk);
            if (sbq.size() > 0 && cyc == sbq[0].c) begin
                s = sbq.pop_front();
                chk("credit_pending", pend_b, s.p);
                chk("credit_urgent", urg_b, s.u);
                chk("credit_overflow", ovf_b, s.o);
                chk("credit_req", req_b, s.r);
            end
        end while (cyc < 310);
        chk("credit_sb_drained", 16'(sbq.size()), 16'd0);

        // Batch grant with the interval counter parked so no new credit arrives.
        init_b = 1'b0;
        en_b = 1'b1;
        push_trace(4);
        run_trace(1'b1, -1);
        en_b = 1'b0;
        chk("batch_pending", pend_b, 4'd0);
        chk("batch_urgent", urg_b, 1'b0);
        chk("batch_overflow_sticky", ovf_b, 1'b1);
        @(negedge clk);
        chk("batch_single_end", end_b, 1'b0);
        chk("batch_idle_cmd", cmd_b, NOP);
        rst_b = 1'b1;
        @(negedge clk);
        chk("overflow_cleared", ovf_b, 1'b0);
        rst_b = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
